// File: rtl/unidade_pc_pkg.sv
// Shared encodings for the program-counter unit: branch types and FSM states.
package unidade_pc_pkg;

  // Tipo_Branch encodings as decoded by the control stage
  typedef enum logic [2:0] {
    TB_REL  = 3'd0,
    TB_BEQ  = 3'd1,
    TB_BNE  = 3'd2,
    TB_BLT  = 3'd3,
    TB_BGE  = 3'd4,
    TB_BLTU = 3'd5,
    TB_JAL  = 3'd6,
    TB_JR   = 3'd7
  } tipo_branch_t;

  // Fetch FSM states
  typedef enum logic {
    EST_RUN  = 1'b0,
    EST_HALT = 1'b1
  } estado_t;

endpackage

// File: rtl/unidade_pc_calc_prox_pc.sv
// Combinational next-PC and taken calculation. No state lives here; the
// owning unit decides whether the result is committed this cycle.
module calc_prox_pc
  import unidade_pc_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic [LARGURA-1:0] pc,
  input  logic               pcsrc,
  input  logic [2:0]         tipo,
  input  logic [LARGURA-1:0] imed,
  input  logic [LARGURA-1:0] rl2out,
  input  logic               zero,
  input  logic               neg,
  input  logic               carry,
  output logic [LARGURA-1:0] prox_pc,
  output logic [LARGURA-1:0] pc_mais1,
  output logic               taken,
  output logic               is_jal
);

  localparam logic [LARGURA-1:0] UM = LARGURA'(1);

  logic [LARGURA-1:0] alvo_rel;   // PC + imed (rel, bltu, jal)
  logic [LARGURA-1:0] alvo_cond;  // PC - 1 + imed (beq/bne/blt/bge)

  assign pc_mais1  = pc + UM;
  assign alvo_rel  = pc + imed;
  assign alvo_cond = pc + imed - UM;

  // Select the next fetch address; not-taken and sequential both fall to PC+1
  always_comb begin
    prox_pc = pc_mais1;
    taken   = 1'b0;
    is_jal  = 1'b0;
    if (pcsrc) begin
      case (tipo)
        TB_REL: begin
          prox_pc = alvo_rel;
          taken   = 1'b1;
        end
        TB_BEQ: if (zero) begin
          prox_pc = alvo_cond;
          taken   = 1'b1;
        end
        TB_BNE: if (!zero) begin
          prox_pc = alvo_cond;
          taken   = 1'b1;
        end
        TB_BLT: if (neg) begin
          prox_pc = alvo_cond;
          taken   = 1'b1;
        end
        TB_BGE: if (zero || !neg) begin
          prox_pc = alvo_cond;
          taken   = 1'b1;
        end
        TB_BLTU: if (carry) begin
          prox_pc = alvo_rel;
          taken   = 1'b1;
        end
        TB_JAL: begin
          prox_pc = alvo_rel;
          taken   = 1'b1;
          is_jal  = 1'b1;
        end
        TB_JR: begin
          prox_pc = rl2out;
          taken   = 1'b1;
        end
        default: begin
          prox_pc = alvo_rel;
          taken   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/unidade_pc.sv
// Program-counter unit: owns the PC, the RUN/HALT fetch FSM, the jal link
// register and a saturating taken-branch counter.
module unidade_pc
  import unidade_pc_pkg::*;
#(
  parameter int                 LARGURA   = 32,
  parameter logic [LARGURA-1:0] PC_RESET  = '0,
  parameter int                 LARG_CONT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 PCSrc,
  input  logic [2:0]           Tipo_Branch,
  input  logic [LARGURA-1:0]   imed,
  input  logic [LARGURA-1:0]   rl2out,
  input  logic                 zero,
  input  logic                 neg,
  input  logic                 carry,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 resume,
  output logic [LARGURA-1:0]   PC,
  output logic [LARGURA-1:0]   link,
  output logic                 desviou,
  output logic                 parado,
  output logic [LARG_CONT-1:0] cont_desvios
);

  estado_t            estado;
  logic [LARGURA-1:0] prox_pc;
  logic [LARGURA-1:0] pc_mais1;
  logic               taken;
  logic               is_jal;

  calc_prox_pc #(.LARGURA(LARGURA)) u_calc (
    .pc       (PC),
    .pcsrc    (PCSrc),
    .tipo     (Tipo_Branch),
    .imed     (imed),
    .rl2out   (rl2out),
    .zero     (zero),
    .neg      (neg),
    .carry    (carry),
    .prox_pc  (prox_pc),
    .pc_mais1 (pc_mais1),
    .taken    (taken),
    .is_jal   (is_jal)
  );

  // FSM plus PC/link/counter update; stall outranks halt, halt outranks a branch
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= EST_RUN;
      PC           <= PC_RESET;
      link         <= '0;
      desviou      <= 1'b0;
      parado       <= 1'b0;
      cont_desvios <= '0;
    end else begin
      desviou <= 1'b0;
      case (estado)
        EST_RUN: begin
          if (!stall) begin
            if (halt) begin
              // branch on the same edge is dropped; PC stays put
              estado <= EST_HALT;
              parado <= 1'b1;
            end else begin
              PC <= prox_pc;
              if (taken) begin
                desviou <= 1'b1;
                if (cont_desvios != '1)
                  cont_desvios <= cont_desvios + LARG_CONT'(1);
                if (is_jal)
                  link <= pc_mais1;
              end
            end
          end
        end
        EST_HALT: begin
          // fetch restarts from the held PC on the cycle after resume
          if (resume) begin
            estado <= EST_RUN;
            parado <= 1'b0;
          end
        end
        default: begin
          estado <= EST_RUN;
          parado <= 1'b0;
        end
      endcase
    end
  end

endmodule
